// File: rtl/brownout_pkg.sv
// Shared types and helpers for the brown-out sequencer.
//   state_t     : sequencer states
//   onehot8()   : 3-bit trip code -> one-hot 8-bit analog mux select
//   BROUT_CNT_W : width of the saturating brown-out event counter
package brownout_pkg;

  localparam int BROUT_CNT_W = 8;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    SETTLE  = 2'd1,
    ARMED   = 2'd2,
    TRIPPED = 2'd3
  } state_t;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    onehot8 = 8'h01 << code;
  endfunction

endpackage

// File: rtl/brownout_sync.sv
// Two-flop synchroniser for an asynchronous comparator output.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input
//   q   : synchronised output
module brownout_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p0 <= 1'b0;
      q    <= 1'b0;
    end else begin
      // stage 0: metastability catch; stage 1: resolved output
      s_p0 <= d;
      q    <= s_p0;
    end
  end

endmodule

// File: rtl/brownout_seq.sv
// Brown-out analog section sequencer, clocked by the section's oscillator.
// Powers up the analog block, waits for it to settle, then debounces the
// brown-out comparator and drives an active-low flag with a minimum hold.
//   osc_ck        : clock
//   rst           : asynchronous active-high reset
//   ena           : block enable (0 forces OFF)
//   otrip, vtrip  : 3-bit trip select codes
//   dbnc_cyc      : debounce length, dbnc_cyc+1 consecutive samples needed
//   cnt_clr       : synchronous clear of brout_cnt
//   dcomp, vunder : asynchronous comparator outputs (dcomp=1 -> supply low)
//   ana_ena       : analog enable
//   otrip_decoded, vtrip_decoded : one-hot mux selects
//   outb_unbuf    : brown-out flag, active low
//   ready         : monitoring armed
//   vunder_s      : synchronised vunder
//   brout_cnt     : saturating brown-out event count
module brownout_seq
  import brownout_pkg::*;
#(
  parameter int SETTLE_CYC = 32,
  parameter int HOLD_CYC   = 16,
  parameter int DBNC_W     = 4
) (
  input  logic                   osc_ck,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [2:0]             otrip,
  input  logic [2:0]             vtrip,
  input  logic [DBNC_W-1:0]      dbnc_cyc,
  input  logic                   cnt_clr,
  input  logic                   dcomp,
  input  logic                   vunder,
  output logic                   ana_ena,
  output logic [7:0]             otrip_decoded,
  output logic [7:0]             vtrip_decoded,
  output logic                   outb_unbuf,
  output logic                   ready,
  output logic                   vunder_s,
  output logic [BROUT_CNT_W-1:0] brout_cnt
);

  localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [SET_W-1:0]       SET_LOAD  = SET_W'(SETTLE_CYC - 1);
  localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [BROUT_CNT_W-1:0] CNT_MAX   = '1;

  state_t              state, state_n;
  logic [SET_W-1:0]    settle_cnt, settle_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic                hold_act, hold_act_n;
  logic [DBNC_W-1:0]   dbnc_cnt, dbnc_n;
  logic                outb_n;
  logic                trip_evt;
  logic                code_chg;
  logic                dcomp_s;

  brownout_sync u_sync_dcomp (
    .clk (osc_ck),
    .rst (rst),
    .d   (dcomp),
    .q   (dcomp_s)
  );

  brownout_sync u_sync_vunder (
    .clk (osc_ck),
    .rst (rst),
    .d   (vunder),
    .q   (vunder_s)
  );

  // The decoded selects always hold the previous cycle's codes, so any
  // difference means a code changed since the last edge.
  assign code_chg = (onehot8(otrip) != otrip_decoded) ||
                    (onehot8(vtrip) != vtrip_decoded);

  always_comb begin
    state_n    = state;
    settle_n   = settle_cnt;
    hold_n     = hold_cnt;
    hold_act_n = hold_act;
    dbnc_n     = dbnc_cnt;
    outb_n     = outb_unbuf;
    trip_evt   = 1'b0;

    if (!ena) begin
      state_n    = OFF;
      settle_n   = '0;
      hold_n     = '0;
      hold_act_n = 1'b0;
      dbnc_n     = '0;
      outb_n     = 1'b0;
    end else if ((state == ARMED || state == TRIPPED) && code_chg) begin
      // Re-settle after a trip-code change; the flag keeps its value.
      state_n    = SETTLE;
      settle_n   = SET_LOAD;
      hold_n     = '0;
      hold_act_n = 1'b0;
      dbnc_n     = '0;
    end else begin
      case (state)
        OFF: begin
          state_n  = SETTLE;
          settle_n = SET_LOAD;
          outb_n   = 1'b0;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            dbnc_n = '0;
            if (dcomp_s) begin
              state_n    = TRIPPED;
              outb_n     = 1'b0;
              hold_n     = HOLD_LOAD;
              hold_act_n = 1'b1;
              trip_evt   = 1'b1;
            end else begin
              state_n = ARMED;
              outb_n  = 1'b1;
            end
          end else begin
            settle_n = settle_cnt - SET_W'(1);
          end
        end
        ARMED: begin
          if (!dcomp_s) begin
            dbnc_n = '0;
          end else if (dbnc_cnt == dbnc_cyc) begin
            state_n    = TRIPPED;
            outb_n     = 1'b0;
            hold_n     = HOLD_LOAD;
            hold_act_n = 1'b1;
            dbnc_n     = '0;
            trip_evt   = 1'b1;
          end else begin
            dbnc_n = dbnc_cnt + DBNC_W'(1);
          end
        end
        TRIPPED: begin
          // hold_act covers HOLD_CYC cycles including the one where the
          // hold counter reads 0; debounce sampling starts afterwards.
          if (hold_act) begin
            dbnc_n = '0;
            if (hold_cnt == '0) hold_act_n = 1'b0;
            else                hold_n     = hold_cnt - HOLD_W'(1);
          end else if (dcomp_s) begin
            dbnc_n = '0;
          end else if (dbnc_cnt == dbnc_cyc) begin
            state_n = ARMED;
            outb_n  = 1'b1;
            dbnc_n  = '0;
          end else begin
            dbnc_n = dbnc_cnt + DBNC_W'(1);
          end
        end
        default: begin
          state_n = OFF;
          outb_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      state         <= OFF;
      settle_cnt    <= '0;
      hold_cnt      <= '0;
      hold_act      <= 1'b0;
      dbnc_cnt      <= '0;
      ana_ena       <= 1'b0;
      ready         <= 1'b0;
      outb_unbuf    <= 1'b0;
      otrip_decoded <= 8'h01;
      vtrip_decoded <= 8'h01;
      brout_cnt     <= '0;
    end else begin
      state         <= state_n;
      settle_cnt    <= settle_n;
      hold_cnt      <= hold_n;
      hold_act      <= hold_act_n;
      dbnc_cnt      <= dbnc_n;
      outb_unbuf    <= outb_n;
      ana_ena       <= (state_n != OFF);
      ready         <= (state_n == ARMED) || (state_n == TRIPPED);
      otrip_decoded <= onehot8(otrip);
      vtrip_decoded <= onehot8(vtrip);
      if (cnt_clr)
        brout_cnt <= '0;
      else if (trip_evt && brout_cnt != CNT_MAX)
        brout_cnt <= brout_cnt + BROUT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_brownout_seq.sv
// Self-checking bench for brownout_seq: directed sequences with literal
// expectations followed by randomized stimulus, all checked every cycle
// against a timestamp/window based behavioural model.
module tb_brownout_seq;

  localparam int SETTLE = 32;
  localparam int HOLD   = 16;
  localparam int DW     = 4;

  localparam int M_OFF = 0;
  localparam int M_SET = 1;
  localparam int M_ARM = 2;
  localparam int M_TRP = 3;

  logic          osc_ck;
  logic          rst;
  logic          ena;
  logic [2:0]    otrip;
  logic [2:0]    vtrip;
  logic [DW-1:0] dbnc_cyc;
  logic          cnt_clr;
  logic          dcomp;
  logic          vunder;
  logic          ana_ena;
  logic [7:0]    otrip_decoded;
  logic [7:0]    vtrip_decoded;
  logic          outb_unbuf;
  logic          ready;
  logic          vunder_s;
  logic [7:0]    brout_cnt;

  brownout_seq #(.SETTLE_CYC(SETTLE), .HOLD_CYC(HOLD), .DBNC_W(DW)) dut (
    .osc_ck        (osc_ck),
    .rst           (rst),
    .ena           (ena),
    .otrip         (otrip),
    .vtrip         (vtrip),
    .dbnc_cyc      (dbnc_cyc),
    .cnt_clr       (cnt_clr),
    .dcomp         (dcomp),
    .vunder        (vunder),
    .ana_ena       (ana_ena),
    .otrip_decoded (otrip_decoded),
    .vtrip_decoded (vtrip_decoded),
    .outb_unbuf    (outb_unbuf),
    .ready         (ready),
    .vunder_s      (vunder_s),
    .brout_cnt     (brout_cnt)
  );

  initial osc_ck = 1'b0;
  always #5 osc_ck = ~osc_ck;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int       n           = 0;   // edges since time zero
  int       mode        = M_OFF;
  int       settle_done = 0;   // edge at which settling completes
  int       win_start   = 0;   // earliest edge whose sample may count
  bit [1:0] d_dly       = '0;  // comparator values seen 1 and 2 edges ago
  bit [1:0] v_dly       = '0;
  bit       seen_h [0:63];     // dcomp_s value used at each edge
  bit [2:0] cur_ot      = '0;
  bit [2:0] cur_vt      = '0;
  int       e_cnt       = 0;
  bit       e_outb      = 0;

  // dbnc_cyc+1 consecutive samples equal to v, all taken at or after win_start
  function automatic bit window_ok(input int at, input bit v);
    if (at - int'(dbnc_cyc) < win_start) return 1'b0;
    for (int k = 0; k <= int'(dbnc_cyc); k++)
      if (seen_h[(at - k) % 64] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mode   = M_OFF;
    d_dly  = '0;
    v_dly  = '0;
    cur_ot = '0;
    cur_vt = '0;
    e_cnt  = 0;
    e_outb = 1'b0;
  endtask

  task automatic model_step();
    bit s, trip, chg;
    n++;
    s     = d_dly[1];
    d_dly = {d_dly[0], dcomp};
    v_dly = {v_dly[0], vunder};
    seen_h[n % 64] = s;
    trip = 1'b0;
    chg  = (otrip != cur_ot) || (vtrip != cur_vt);
    if (!ena) begin
      mode = M_OFF;
    end else if (mode == M_OFF) begin
      mode = M_SET; settle_done = n + SETTLE;
    end else if (mode == M_SET) begin
      if (n == settle_done) begin
        if (s) begin mode = M_TRP; win_start = n + HOLD + 1; trip = 1'b1; end
        else   begin mode = M_ARM; win_start = n + 1; end
      end
    end else if (chg) begin
      mode = M_SET; settle_done = n + SETTLE;
    end else if (mode == M_ARM && window_ok(n, 1'b1)) begin
      mode = M_TRP; win_start = n + HOLD + 1; trip = 1'b1;
    end else if (mode == M_TRP && window_ok(n, 1'b0)) begin
      mode = M_ARM; win_start = n + 1;
    end
    cur_ot = otrip;
    cur_vt = vtrip;
    if (cnt_clr) e_cnt = 0;
    else if (trip && e_cnt < 255) e_cnt++;
    if (mode == M_ARM) e_outb = 1'b1;
    else if (mode != M_SET) e_outb = 1'b0;
  endtask

  always @(posedge osc_ck or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_ana_ena", 32'(ana_ena), 32'(mode != M_OFF));
    chk("m_ready", 32'(ready), 32'(mode == M_ARM || mode == M_TRP));
    chk("m_outb_unbuf", 32'(outb_unbuf), 32'(e_outb));
    chk("m_vunder_s", 32'(vunder_s), 32'(v_dly[1]));
    chk("m_brout_cnt", 32'(brout_cnt), 32'(e_cnt));
    chk("m_otrip_decoded", 32'(otrip_decoded), 32'(8'h01 << cur_ot));
    chk("m_vtrip_decoded", 32'(vtrip_decoded), 32'(8'h01 << cur_vt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ana_ena"}, 32'(ana_ena), 32'd0);
    chk({tag, "_outb"}, 32'(outb_unbuf), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_vunder_s"}, 32'(vunder_s), 32'd0);
    chk({tag, "_brout_cnt"}, 32'(brout_cnt), 32'd0);
    chk({tag, "_otrip_dec"}, 32'(otrip_decoded), 32'h01);
    chk({tag, "_vtrip_dec"}, 32'(vtrip_decoded), 32'h01);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge osc_ck);
    #2;
  endtask

  // ---------------- stimulus ----------------
  task automatic run_directed();
    rst = 1'b1; ena = 1'b0; otrip = 3'd3; vtrip = 3'd2; dbnc_cyc = 4'd4;
    cnt_clr = 1'b0; dcomp = 1'b0; vunder = 1'b0;
    #1;
    chk_reset_vals("rst0");
    tick(2);
    rst = 1'b0; ena = 1'b1;
    // power-up
    tick(1);
    chk("pu_otrip_dec", 32'(otrip_decoded), 32'h08);
    chk("pu_vtrip_dec", 32'(vtrip_decoded), 32'h04);
    chk("pu_ana_ena", 32'(ana_ena), 32'd1);
    tick(31);
    chk("pu_ready_e32", 32'(ready), 32'd0);
    tick(1);
    chk("pu_ready_e33", 32'(ready), 32'd1);
    chk("pu_outb_e33", 32'(outb_unbuf), 32'd1);
    // debounce: 4-sample pulse rejected, 5-sample pulse trips 7 edges later
    tick(3);
    dcomp = 1'b1; tick(4); dcomp = 1'b0;
    tick(8);
    chk("dbnc4_outb", 32'(outb_unbuf), 32'd1);
    chk("dbnc4_cnt", 32'(brout_cnt), 32'd0);
    dcomp = 1'b1; tick(5); dcomp = 1'b0;
    tick(1);
    chk("dbnc5_outb_e6", 32'(outb_unbuf), 32'd1);
    tick(1);
    chk("dbnc5_outb_e7", 32'(outb_unbuf), 32'd0);
    chk("dbnc5_cnt", 32'(brout_cnt), 32'd1);
    // hold: 16 cycles plus one debounce sample
    dbnc_cyc = 4'd0;
    tick(16);
    chk("hold_outb_16", 32'(outb_unbuf), 32'd0);
    tick(1);
    chk("hold_outb_17", 32'(outb_unbuf), 32'd1);
    // re-settle on vtrip change
    tick(2);
    vtrip = 3'd5;
    tick(1);
    chk("rs_vtrip_dec", 32'(vtrip_decoded), 32'h20);
    chk("rs_ready", 32'(ready), 32'd0);
    chk("rs_outb", 32'(outb_unbuf), 32'd1);
    tick(31);
    chk("rs_ready_32", 32'(ready), 32'd0);
    chk("rs_outb_32", 32'(outb_unbuf), 32'd1);
    tick(1);
    chk("rs_ready_33", 32'(ready), 32'd1);
    chk("rs_cnt", 32'(brout_cnt), 32'd1);
    // disable mid-TRIPPED
    dcomp = 1'b1;
    tick(3);
    chk("dis_trip_outb", 32'(outb_unbuf), 32'd0);
    chk("dis_trip_cnt", 32'(brout_cnt), 32'd2);
    tick(2);
    ena = 1'b0;
    tick(1);
    chk("dis_ana_ena", 32'(ana_ena), 32'd0);
    chk("dis_ready", 32'(ready), 32'd0);
    chk("dis_cnt_kept", 32'(brout_cnt), 32'd2);
    // power-up with comparator already tripped
    cnt_clr = 1'b1;
    tick(1);
    chk("clr_off", 32'(brout_cnt), 32'd0);
    cnt_clr = 1'b0; ena = 1'b1;
    tick(32);
    chk("putrip_ready_31", 32'(ready), 32'd0);
    tick(1);
    chk("putrip_ready", 32'(ready), 32'd1);
    chk("putrip_outb", 32'(outb_unbuf), 32'd0);
    chk("putrip_cnt", 32'(brout_cnt), 32'd1);
    // clear and trip on the same edge
    dcomp = 1'b0;
    tick(25);
    chk("pre_clr_outb", 32'(outb_unbuf), 32'd1);
    dcomp = 1'b1;
    tick(2);
    cnt_clr = 1'b1; dcomp = 1'b0;
    tick(1);
    chk("clr_trip_cnt", 32'(brout_cnt), 32'd0);
    chk("clr_trip_outb", 32'(outb_unbuf), 32'd0);
    cnt_clr = 1'b0;
    // saturation
    tick(25);
    for (int i = 0; i < 260; i++) begin
      dcomp = 1'b1; tick(1); dcomp = 1'b0; tick(21);
      if (i == 99) chk("sat_cnt_100", 32'(brout_cnt), 32'd100);
    end
    chk("sat_cnt_255", 32'(brout_cnt), 32'd255);
    // asynchronous reset mid-SETTLE
    ena = 1'b0;
    tick(2);
    ena = 1'b1;
    tick(5);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    tick(2);
    rst = 1'b0;
  endtask

  task automatic run_random();
    for (int i = 0; i < 3000; i++) begin
      if (!ena) begin
        dbnc_cyc = DW'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) ena = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        ena = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) dcomp = ~dcomp;
      if ($urandom_range(0, 149) == 0) begin
        otrip = 3'($urandom_range(0, 7));
        vtrip = 3'($urandom_range(0, 7));
      end
      cnt_clr = ($urandom_range(0, 99) == 0);
      vunder  = 1'($urandom_range(0, 1));
      tick(1);
    end
  endtask

  initial begin
    fork
      begin
        run_directed();
        run_random();
        tick(4);
      end
      forever begin
        @(negedge osc_ck);
        cmp_model();
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
